act_quant_pipe: RTL

Multi-lane pipelined requantization and activation unit that replaces the single-value Q4.4 `saturate`/`relu`/`tanh_approx` helpers. It sits between the MAC array accumulators and the output/activation BRAM write path. It converts LANES signed accumulators per beat through four steps: bias add, configurable rounding right-shift, saturation to OUT_W, then a selectable activation. It uses valid/ready handshakes on both sides and keeps a saturation statistics counter.

---
 rtl/act_quant_pipe_pkg.sv | 36 +++
 rtl/act_quant_lane.sv | 90 +++++++++
 rtl/act_quant_pipe.sv | 71 +++++++
 3 files changed

// File: rtl/act_quant_pipe_pkg.sv
// Shared types, default lane counts and the piecewise-linear tanh used by the
// requantization/activation pipeline.
package act_quant_pipe_pkg;

    typedef enum logic [1:0] {
        ACT_NONE = 2'd0,
        ACT_RELU = 2'd1,
        ACT_TANH = 2'd2
    } act_mode_e;

    localparam int MLP_MACS  = 8;
    localparam int CNN_MACS  = 9;
    localparam int RNN_MACS  = 4;
    localparam int DEF_LANES = RNN_MACS;

    // Fixed working width of tanh_pwl; callers sign-extend into it (OUT_W < PWL_W).
    localparam int PWL_W = 16;

    // Three-segment odd tanh: identity, slope 1/4, then flat at ONE.
    function automatic logic signed [PWL_W-1:0] tanh_pwl(input logic signed [PWL_W-1:0] q,
                                                         input int frac_bits);
        logic [PWL_W:0]   a, one, h, b, k, y;
        logic [PWL_W-1:0] m;
        one = (PWL_W+1)'(1) << frac_bits;
        h   = one >> 1;
        b   = ((one << 2) + one) >> 1;
        k   = ((one << 1) + one) >> 3;
        a   = q[PWL_W-1] ? -{q[PWL_W-1], q} : {q[PWL_W-1], q};
        if (a < h)      y = a;
        else if (a < b) y = k + (a >> 2);
        else            y = one;
        m = y[PWL_W-1:0];
        return q[PWL_W-1] ? -m : m;
    endfunction

endpackage

// File: rtl/act_quant_lane.sv
// One lane of the requantizer: bias add, rounding shift, clamp + activation,
// one register stage each. Config rides along with the data.
module act_quant_lane
    import act_quant_pipe_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 8,
    parameter int FRAC_BITS = 4,
    parameter int SHIFT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         en,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               cfg_round,
    input  logic [1:0]         cfg_act,
    input  logic [IN_W-1:0]    acc,
    input  logic [IN_W-1:0]    bias,
    output logic [OUT_W-1:0]   q_out,
    output logic               sat
);

    localparam logic signed [IN_W+1:0] Q_MAX = (IN_W+2)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [IN_W+1:0] Q_MIN = ~Q_MAX;

    logic signed [IN_W:0]   s1;
    logic [SHIFT_W-1:0]     sh1;
    logic                   rnd1;
    logic [1:0]             act1, act2;
    logic signed [IN_W+1:0] r2;

    logic signed [IN_W+1:0] rnd_add, s2w;
    logic [OUT_W-1:0]       q_c, y_c;
    logic                   sat_c;
    logic signed [PWL_W-1:0] t_c;

    always_comb begin
        rnd_add = '0;
        if (rnd1 && sh1 != '0)
            rnd_add = (IN_W+2)'(1) << (sh1 - SHIFT_W'(1));
        s2w = $signed({s1[IN_W], s1}) + rnd_add;
    end

    always_comb begin
        q_c   = r2[OUT_W-1:0];
        sat_c = 1'b0;
        if (r2 > Q_MAX) begin
            q_c   = Q_MAX[OUT_W-1:0];
            sat_c = 1'b1;
        end else if (r2 < Q_MIN) begin
            q_c   = Q_MIN[OUT_W-1:0];
            sat_c = 1'b1;
        end
        t_c = tanh_pwl({{(PWL_W-OUT_W){q_c[OUT_W-1]}}, q_c}, FRAC_BITS);
        case (act_mode_e'(act2))
            ACT_RELU: y_c = q_c[OUT_W-1] ? '0 : q_c;
            ACT_TANH: y_c = t_c[OUT_W-1:0];
            default:  y_c = q_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            sh1   <= '0;
            rnd1  <= 1'b0;
            act1  <= '0;
            r2    <= '0;
            act2  <= '0;
            q_out <= '0;
            sat   <= 1'b0;
        end else begin
            if (en[0]) begin
                s1   <= $signed({acc[IN_W-1], acc}) + $signed({bias[IN_W-1], bias});
                sh1  <= cfg_shift;
                rnd1 <= cfg_round;
                act1 <= cfg_act;
            end
            if (en[1]) begin
                r2   <= s2w >>> sh1;
                act2 <= act1;
            end
            if (en[2]) begin
                q_out <= y_c;
                sat   <= sat_c;
            end
        end
    end

endmodule

// File: rtl/act_quant_pipe.sv
// LANES-wide requantize/activate pipeline with a global-stall valid/ready
// handshake and a sticky saturation-beat counter.
module act_quant_pipe
    import act_quant_pipe_pkg::*;
#(
    parameter int LANES     = DEF_LANES,
    parameter int IN_W      = 16,
    parameter int OUT_W     = 8,
    parameter int FRAC_BITS = 4,
    parameter int SHIFT_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SHIFT_W-1:0]     cfg_shift,
    input  logic                   cfg_round,
    input  logic [1:0]             cfg_act,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_acc,
    input  logic [LANES*IN_W-1:0]  in_bias,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [LANES-1:0]       out_sat,
    input  logic                   stat_clr,
    output logic [15:0]            sat_count
);

    localparam int STAGES = 3;

    logic [STAGES:1] vld_pipe;
    logic            adv, out_hs;
    logic [2:0]      lane_en;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];
    assign out_hs    = out_valid && out_ready;
    // Stages only load real beats, so bubbles never disturb the held output.
    assign lane_en   = {adv && vld_pipe[2], adv && vld_pipe[1], adv && in_valid};

    always_ff @(posedge clk) begin
        if (rst)      vld_pipe <= '0;
        else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    always_ff @(posedge clk) begin
        if (rst || stat_clr)
            sat_count <= '0;
        else if (out_hs && |out_sat && sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        act_quant_lane #(
            .IN_W(IN_W), .OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS), .SHIFT_W(SHIFT_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .en        (lane_en),
            .cfg_shift (cfg_shift),
            .cfg_round (cfg_round),
            .cfg_act   (cfg_act),
            .acc       (in_acc[i*IN_W +: IN_W]),
            .bias      (in_bias[i*IN_W +: IN_W]),
            .q_out     (out_data[i*OUT_W +: OUT_W]),
            .sat       (out_sat[i])
        );
    end

endmodule
